// File: rtl/k2_sequencer_if.sv
// Instruction-memory port of the K2 sequencer: fetch request/address out,
// ack/data back. master = sequencer, slave = instruction memory.
interface k2_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [7:0]        imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/k2_sequencer.sv
// K2 fetch/decode/execute controller: fetches bytes over imem, drives ALU
// select and register write enables, holds C/Z flags for conditional jumps.
// Ports: clk, rst_n (sync, active-low), run, imem (master), c/z flags in,
// alu_s, ra_en/rb_en/ro_en, src_sel, imm, halted.
module k2_sequencer #(
    parameter int BITS   = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    k2_sequencer_if.master  imem,
    input  logic            c,
    input  logic            z,
    output logic            alu_s,
    output logic            ra_en,
    output logic            rb_en,
    output logic            ro_en,
    output logic            src_sel,
    output logic [BITS-1:0] imm,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_FLAG,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic              c_q;
    logic              z_q;
    logic              req;

    logic              is_alu;
    logic              is_ldi;
    logic              is_jmp;
    logic              is_halt;
    logic              taken;
    logic              wr_a;
    logic              wr_b;
    logic              wr_o;
    logic              wr_imm;
    logic [1:0]        dd;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign imm            = BITS'(ir[3:0]);

    assign is_alu  = (ir[7:6] == 2'b00);
    assign is_ldi  = (ir[7:6] == 2'b01);
    assign is_jmp  = (ir[7:6] == 2'b10);
    assign is_halt = (ir[7:6] == 2'b11) && ir[5];

    // ALU ops keep the op select in IR[5] (it drives alu_s directly),
    // so their destination lives in IR[4:3]; LDI uses IR[5:4].
    assign dd = is_alu ? ir[4:3] : ir[5:4];

    always_comb begin
        taken = 1'b0;
        if (is_jmp) begin
            unique case (ir[5:4])
                2'b00: taken = 1'b1;
                2'b01: taken = c_q;
                2'b10: taken = z_q;
                2'b11: taken = !z_q;
            endcase
        end
    end

    always_comb begin
        wr_a   = 1'b0;
        wr_b   = 1'b0;
        wr_o   = 1'b0;
        wr_imm = 1'b0;
        if (is_alu || is_ldi) begin
            unique case (dd)
                2'b00:   wr_a = 1'b1;
                2'b01:   wr_b = 1'b1;
                2'b10:   wr_o = 1'b1;
                default: ;
            endcase
            wr_imm = is_ldi && (dd != 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            req     <= 1'b0;
            alu_s   <= 1'b0;
            ra_en   <= 1'b0;
            rb_en   <= 1'b0;
            ro_en   <= 1'b0;
            src_sel <= 1'b0;
            halted  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        req   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        ir    <= imem.imem_data;
                        alu_s <= imem.imem_data[5];
                        req   <= 1'b0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        alu_s  <= 1'b0;
                    end else begin
                        state   <= S_EXEC;
                        ra_en   <= wr_a;
                        rb_en   <= wr_b;
                        ro_en   <= wr_o;
                        src_sel <= wr_imm;
                    end
                end
                S_EXEC: begin
                    ra_en   <= 1'b0;
                    rb_en   <= 1'b0;
                    ro_en   <= 1'b0;
                    src_sel <= 1'b0;
                    pc      <= taken ? ADDR_W'(ir[3:0])
                                     : pc + ADDR_W'(1);
                    if (is_alu) begin
                        state <= S_FLAG;
                    end else begin
                        state <= S_FETCH;
                        req   <= 1'b1;
                        alu_s <= 1'b0;
                    end
                end
                S_FLAG: begin
                    // ALU block registered its flags at the end of EXEC
                    c_q   <= c;
                    z_q   <= z;
                    state <= S_FETCH;
                    req   <= 1'b1;
                    alu_s <= 1'b0;
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_k2_sequencer.sv
// Bench for k2_sequencer: ISA-level reference model feeds a scoreboard,
// a monitor checks fetches and register writes as the DUT presents them.
module tb_k2_sequencer;
    localparam int ADDR_W = 4;
    localparam int BITS   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run = 1'b0;
    logic            c;
    logic            z;
    logic            alu_s;
    logic            ra_en;
    logic            rb_en;
    logic            ro_en;
    logic            src_sel;
    logic [BITS-1:0] imm;
    logic            halted;

    k2_sequencer_if #(.ADDR_W(ADDR_W)) imem_bus ();

    k2_sequencer #(.BITS(BITS), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .imem    (imem_bus),
        .c       (c),
        .z       (z),
        .alu_s   (alu_s),
        .ra_en   (ra_en),
        .rb_en   (rb_en),
        .ro_en   (ro_en),
        .src_sel (src_sel),
        .imm     (imm),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ALU block environment: A/B/O registers and registered C/Z flags
    logic [7:0] ea, eb, eo;
    logic       ec, ez;
    wire  [7:0] alu_y = alu_s ? ea - eb : ea + eb;

    always @(posedge clk) begin
        if (!rst_n) begin
            ea <= 0; eb <= 0; eo <= 0; ec <= 0; ez <= 0;
        end else begin
            ec <= alu_s ? (ea >= eb) : (({1'b0, ea} + {1'b0, eb}) > 9'd255);
            ez <= (alu_y == 8'd0);
            if (ra_en) ea <= src_sel ? imm : alu_y;
            if (rb_en) eb <= src_sel ? imm : alu_y;
            if (ro_en) eo <= src_sel ? imm : alu_y;
        end
    end
    assign c = ec;
    assign z = ez;

    // instruction memory
    logic [7:0] mem [16];
    int ack_mode = 0;
    int fetch_limit = 0;
    int nfetch = 0;
    int hold = 0;

    initial begin
        imem_bus.imem_ack  = 1'b0;
        imem_bus.imem_data = 8'h00;
    end

    always @(posedge clk) begin
        bit g;
        #1;
        g = 0;
        if (imem_bus.imem_req && nfetch < fetch_limit) begin
            if (ack_mode == 1) g = 1;
            else if (ack_mode == 2) begin
                if (hold == 5) begin g = 1; hold = 0; end
                else hold++;
            end else g = ($urandom % 100) < 60;
        end
        if (g) begin
            imem_bus.imem_ack  = 1'b1;
            imem_bus.imem_data = mem[imem_bus.imem_addr];
            nfetch++;
        end else begin
            imem_bus.imem_ack  = !imem_bus.imem_req && ($urandom % 4 == 0);
            imem_bus.imem_data = 8'($urandom);
        end
    end

    // scoreboard
    int          exp_fetch[$];
    logic [31:0] exp_wr[$];
    bit          m_halted;
    int          m_pc;

    function automatic logic [31:0] pack(bit s, bit src, logic [1:0] d,
                                         logic [3:0] im);
        return {19'b0, s, src, d == 2'd0, d == 2'd1, d == 2'd2, 4'b0, im};
    endfunction

    task automatic model_run(int limit);
        int pc = 0, a = 0, b = 0, n = 0, res;
        bit cq = 0, zq = 0, tk;
        logic [7:0] ir;
        m_halted = 0;
        while (n < limit) begin
            ir = mem[pc];
            exp_fetch.push_back(pc);
            n++;
            case (ir[7:6])
                2'b00: begin
                    res = ir[5] ? a - b : a + b;
                    cq  = ir[5] ? (a >= b) : (res > 255);
                    res = res & 255;
                    zq  = (res == 0);
                    if (ir[4:3] == 2'd0) a = res;
                    if (ir[4:3] == 2'd1) b = res;
                    if (ir[4:3] != 2'd3)
                        exp_wr.push_back(pack(ir[5], 0, ir[4:3], ir[3:0]));
                    pc = (pc + 1) % 16;
                end
                2'b01: begin
                    if (ir[5:4] == 2'd0) a = int'(ir[3:0]);
                    if (ir[5:4] == 2'd1) b = int'(ir[3:0]);
                    if (ir[5:4] != 2'd3)
                        exp_wr.push_back(pack(ir[5], 1, ir[5:4], ir[3:0]));
                    pc = (pc + 1) % 16;
                end
                2'b10: begin
                    case (ir[5:4])
                        2'd0: tk = 1;
                        2'd1: tk = cq;
                        2'd2: tk = zq;
                        default: tk = !zq;
                    endcase
                    pc = tk ? int'(ir[3:0]) : (pc + 1) % 16;
                end
                default: begin
                    if (ir[5]) begin m_halted = 1; break; end
                    pc = (pc + 1) % 16;
                end
            endcase
        end
        m_pc = pc;
    endtask

    // monitor
    always @(negedge clk) begin
        if (imem_bus.imem_req && imem_bus.imem_ack) begin
            if (exp_fetch.size() == 0)
                check("fetch_extra", 32'(imem_bus.imem_addr), 32'hFFFF);
            else
                check("fetch_addr", 32'(imem_bus.imem_addr),
                      32'(exp_fetch.pop_front()));
        end
        if (ra_en || rb_en || ro_en || src_sel) begin
            logic [31:0] got;
            got = {19'b0, alu_s, src_sel, ra_en, rb_en, ro_en, imm};
            if (exp_wr.size() == 0) check("wr_extra", got, 32'hFFFF);
            else check("wr_event", got, exp_wr.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        run = 0; rst_n = 0; fetch_limit = 0;
        @(negedge clk);
        check("reset_outs", {16'b0, imem_bus.imem_req, alu_s, ra_en, rb_en,
                             ro_en, src_sel, halted, imm, imem_bus.imem_addr},
              32'h0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic start_prog(int limit);
        do_reset();
        exp_fetch.delete();
        exp_wr.delete();
        model_run(limit);
        nfetch = 0;
        hold = 0;
        fetch_limit = limit;
        run = 1;
    endtask

    task automatic finish_prog(int limit);
        int cyc = 0;
        while (!(halted || nfetch >= limit) && cyc < 3000) begin
            @(negedge clk);
            run = 1'($urandom);
            cyc++;
        end
        check("done_in_time", 32'(cyc < 3000), 32'd1);
        repeat (10) begin
            @(negedge clk);
            run = 1'($urandom);
        end
        run = 0;
        check("halted", 32'(halted), 32'(m_halted));
        check("final_pc", 32'(imem_bus.imem_addr), 32'(m_pc));
        check("req_state", 32'(imem_bus.imem_req), 32'(!m_halted));
        check("sb_drain", 32'(exp_fetch.size() + exp_wr.size()), 32'd0);
    endtask

    task automatic fill(logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    initial begin
        int cyc, cnt;
        bit stable;

        // LDI A,5; LDI B,3; ADD->O; HALT with immediate ack
        fill(8'hE0);
        mem[0] = 8'h45; mem[1] = 8'h53; mem[2] = 8'h10; mem[3] = 8'hE0;
        ack_mode = 1;
        start_prog(30);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            run = 0;
        end while (!halted && cyc < 100);
        check("halt_cycle", 32'(cyc), 32'd13);
        finish_prog(30);

        // compare-sub then JMP z: taken with A==B, not taken with A!=B
        fill(8'hE0);
        mem[0] = 8'h38; mem[1] = 8'hAA;
        start_prog(30);
        finish_prog(30);
        fill(8'hE0);
        mem[0] = 8'h41; mem[1] = 8'h38; mem[2] = 8'hAB;
        start_prog(30);
        finish_prog(30);

        // ack withheld 5 cycles on every fetch
        fill(8'hE0);
        mem[0] = 8'h45; mem[1] = 8'h12;
        ack_mode = 2;
        start_prog(30);
        cnt = 0; stable = 1; cyc = 0;
        do begin
            @(negedge clk);
            run = 0;
            cyc++;
            if (imem_bus.imem_req) begin
                cnt++;
                if (imem_bus.imem_addr != 0) stable = 0;
            end
        end while (!(imem_bus.imem_req && imem_bus.imem_ack) && cyc < 50);
        check("req_cycles", 32'(cnt), 32'd6);
        check("addr_stable", 32'(stable), 32'd1);
        finish_prog(30);

        // pc wrap through NOPs, and a self-loop at 0xF
        fill(8'hC0);
        ack_mode = 0;
        start_prog(17);
        finish_prog(17);
        mem[15] = 8'h8F;
        start_prog(20);
        finish_prog(20);

        // reset during EXEC of an LDI
        fill(8'hE0);
        mem[0] = 8'h45;
        ack_mode = 1;
        start_prog(30);
        cyc = 0;
        do begin
            @(negedge clk);
            run = 0;
            cyc++;
        end while (!ra_en && cyc < 50);
        check("exec_seen", 32'(ra_en), 32'd1);
        rst_n = 0;
        @(negedge clk);
        check("rst_in_exec", {17'b0, imem_bus.imem_req, alu_s, ra_en, rb_en,
                              ro_en, src_sel, halted, 4'b0,
                              imem_bus.imem_addr}, 32'h0);
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            check("idle_no_req", {27'b0, imem_bus.imem_req,
                                  imem_bus.imem_addr}, 32'h0);
        end
        exp_fetch.delete();
        exp_wr.delete();

        // random programs
        ack_mode = 0;
        repeat (40) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            start_prog(30);
            finish_prog(30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
